// File: rtl/hazard_scoreboard.sv
// Hazard and bypass controller: tracks in-flight destination registers across the
// post-ID slots and produces per-operand stall requests and forwarding selects.
module hazard_scoreboard #(
  parameter int unsigned AW     = 5,
  parameter int unsigned STAGES = 3,
  parameter int unsigned FWD_EN = 1,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned SW    = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_rs,
  input  logic              id_rs_used,
  input  logic [AW-1:0]     id_rt,
  input  logic              id_rt_used,
  input  logic [AW-1:0]     id_dst,
  input  logic              id_wr,
  input  logic              id_is_load,
  input  logic              flush,
  input  logic              hold,
  output logic              stall,
  output logic [SW-1:0]     fwd_rs_sel,
  output logic [SW-1:0]     fwd_rt_sel,
  output logic [STAGES-1:0] slot_valid,
  output logic [AW-1:0]     wb_dst,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Index k-1 holds slot k (index 0 = EX, index STAGES-1 = WB).
  logic [STAGES-1:0] slot_v;
  logic [STAGES-1:0] slot_ld;
  logic [AW-1:0]     slot_dst [STAGES];

  logic [STAGES-1:0] rs_hit;
  logic [STAGES-1:0] rt_hit;
  logic [SW-1:0]     rs_young;
  logic [SW-1:0]     rt_young;
  logic              hazard_fwd;
  logic              hazard_nofwd;
  logic              hazard;
  logic              issue;

  // Per-slot operand matches and youngest-match selection.
  always_comb begin
    rs_hit   = '0;
    rt_hit   = '0;
    rs_young = '0;
    rt_young = '0;
    for (int k = 0; k < STAGES; k++) begin
      rs_hit[k] = slot_v[k] && (slot_dst[k] == id_rs) && (id_rs != '0) && id_rs_used;
      rt_hit[k] = slot_v[k] && (slot_dst[k] == id_rt) && (id_rt != '0) && id_rt_used;
    end
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (rs_hit[k]) rs_young = SW'(k + 1);
      if (rt_hit[k]) rt_young = SW'(k + 1);
    end
  end

  // With bypass only a load sitting in EX blocks; without it, anything before WB does.
  assign hazard_fwd   = (rs_hit[0] | rt_hit[0]) & slot_ld[0];
  assign hazard_nofwd = (|rs_hit[STAGES-2:0]) | (|rt_hit[STAGES-2:0]);
  assign hazard       = (FWD_EN != 0) ? hazard_fwd : hazard_nofwd;

  assign stall      = id_valid & ~flush & hazard;
  assign fwd_rs_sel = (FWD_EN != 0) ? rs_young : '0;
  assign fwd_rt_sel = (FWD_EN != 0) ? rt_young : '0;

  assign issue      = id_valid & ~flush & ~stall & id_wr & (id_dst != '0);
  assign slot_valid = slot_v;
  assign wb_dst     = slot_dst[STAGES-1];

  // Slot shift register and saturating stall counter; hold freezes both.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_v    <= '0;
      slot_ld   <= '0;
      stall_cnt <= '0;
      for (int k = 0; k < STAGES; k++) slot_dst[k] <= '0;
    end else if (!hold) begin
      slot_v  <= {slot_v[STAGES-2:0], issue};
      slot_ld <= {slot_ld[STAGES-2:0], id_is_load};
      for (int k = STAGES - 1; k > 0; k--) slot_dst[k] <= slot_dst[k-1];
      slot_dst[0] <= id_dst;
      if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: three instances (bypass, no-bypass, 2-bit counter) share
// stimulus; a table, hand sequences and random cycles are checked against a queue model.
module tb_hazard_scoreboard;

  localparam int STG = 3;

  typedef struct {
    int r, h, f, v, rs, rsu, rt, rtu, dst, wr, ld;
    int est, ers, ert, esv, ecnt, ewb;  // est < 0: no directed check; ewb < 0: skip wb_dst
  } vec_t;

  typedef struct {
    int          m;
    logic [4:0]  dst;
    bit          ld;
    int          age;
  } ent_t;

  logic       clk;
  logic       rst_n, hold, flush, id_valid, id_rs_used, id_rt_used, id_wr, id_is_load;
  logic [4:0] id_rs, id_rt, id_dst;

  logic        st_a  [3];
  logic [1:0]  rs_a  [3];
  logic [1:0]  rt_a  [3];
  logic [2:0]  sv_a  [3];
  logic [4:0]  wb_a  [3];
  logic [15:0] cnt_a [3];

  int   nvec = 0;
  int   nerr = 0;
  bit   model_ok = 0;
  ent_t ents[$];
  int   mcnt [3];
  bit   m_stall [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned CW = (g == 2) ? 2 : 16;
    logic [CW-1:0] cnt;
    hazard_scoreboard #(.AW(5), .STAGES(STG), .FWD_EN((g == 1) ? 0 : 1), .CNT_W(CW)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
      .id_rs(id_rs), .id_rs_used(id_rs_used), .id_rt(id_rt), .id_rt_used(id_rt_used),
      .id_dst(id_dst), .id_wr(id_wr), .id_is_load(id_is_load),
      .flush(flush), .hold(hold),
      .stall(st_a[g]), .fwd_rs_sel(rs_a[g]), .fwd_rt_sel(rt_a[g]),
      .slot_valid(sv_a[g]), .wb_dst(wb_a[g]), .stall_cnt(cnt)
    );
    assign cnt_a[g] = 16'(cnt);
  end

  function automatic bit fwd_of(input int m);
    return m != 1;
  endfunction

  function automatic int cmax_of(input int m);
    return (m == 2) ? 3 : 65535;
  endfunction

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endfunction

  // Youngest producer (smallest age) per operand decides bypass and load-use.
  function automatic void model_eval(input int m, output bit st, output int rs_sel, output int rt_sel);
    int yrs = 0, yrt = 0;
    bit ldrs = 0, ldrt = 0, early = 0, hz;
    foreach (ents[i]) begin
      if (ents[i].m == m) begin
        if (id_rs_used && id_rs != 5'd0 && ents[i].dst == id_rs) begin
          if (yrs == 0 || ents[i].age < yrs) begin yrs = ents[i].age; ldrs = ents[i].ld; end
          if (ents[i].age < STG) early = 1;
        end
        if (id_rt_used && id_rt != 5'd0 && ents[i].dst == id_rt) begin
          if (yrt == 0 || ents[i].age < yrt) begin yrt = ents[i].age; ldrt = ents[i].ld; end
          if (ents[i].age < STG) early = 1;
        end
      end
    end
    hz     = fwd_of(m) ? ((yrs == 1 && ldrs) || (yrt == 1 && ldrt)) : early;
    st     = id_valid && !flush && hz;
    rs_sel = fwd_of(m) ? yrs : 0;
    rt_sel = fwd_of(m) ? yrt : 0;
  endfunction

  function automatic int model_sv(input int m);
    int s = 0;
    foreach (ents[i]) if (ents[i].m == m) s |= (1 << (ents[i].age - 1));
    return s;
  endfunction

  function automatic int model_wb(input int m);
    int w = -1;
    foreach (ents[i]) if (ents[i].m == m && ents[i].age == STG) w = int'(ents[i].dst);
    return w;
  endfunction

  function automatic void model_clock();
    ent_t e;
    if (!rst_n) begin
      ents.delete();
      for (int m = 0; m < 3; m++) mcnt[m] = 0;
      model_ok = 1;
      return;
    end
    if (hold) return;
    for (int i = ents.size() - 1; i >= 0; i--) begin
      e = ents[i];
      e.age++;
      if (e.age > STG) ents.delete(i);
      else ents[i] = e;
    end
    for (int m = 0; m < 3; m++) begin
      if (m_stall[m] && mcnt[m] < cmax_of(m)) mcnt[m]++;
      if (id_valid && !flush && !m_stall[m] && id_wr && id_dst != 5'd0) begin
        e.m = m; e.dst = id_dst; e.ld = id_is_load; e.age = 1;
        ents.push_back(e);
      end
    end
  endfunction

  // One cycle: drive at negedge, check mid-cycle, advance the model at posedge.
  task automatic apply(input vec_t x, input int d);
    int mrs, mrt, w;
    @(negedge clk);
    rst_n = (x.r != 0); hold = (x.h != 0); flush = (x.f != 0); id_valid = (x.v != 0);
    id_rs = 5'(x.rs); id_rs_used = (x.rsu != 0); id_rt = 5'(x.rt); id_rt_used = (x.rtu != 0);
    id_dst = 5'(x.dst); id_wr = (x.wr != 0); id_is_load = (x.ld != 0);
    #1;
    for (int m = 0; m < 3; m++) begin
      model_eval(m, m_stall[m], mrs, mrt);
      if (model_ok) begin
        chk($sformatf("model%0d stall", m), 32'(st_a[m]), 32'(m_stall[m]));
        if (!m_stall[m]) begin
          chk($sformatf("model%0d rs_sel", m), 32'(rs_a[m]), mrs);
          chk($sformatf("model%0d rt_sel", m), 32'(rt_a[m]), mrt);
        end
        chk($sformatf("model%0d slot_valid", m), 32'(sv_a[m]), model_sv(m));
        chk($sformatf("model%0d stall_cnt", m), 32'(cnt_a[m]), mcnt[m]);
        w = model_wb(m);
        if (w >= 0) chk($sformatf("model%0d wb_dst", m), 32'(wb_a[m]), w);
      end
    end
    if (x.est >= 0) begin
      chk($sformatf("dut%0d stall", d), 32'(st_a[d]), x.est);
      if (x.est == 0) begin
        chk($sformatf("dut%0d fwd_rs_sel", d), 32'(rs_a[d]), x.ers);
        chk($sformatf("dut%0d fwd_rt_sel", d), 32'(rt_a[d]), x.ert);
      end
      chk($sformatf("dut%0d slot_valid", d), 32'(sv_a[d]), x.esv);
      chk($sformatf("dut%0d stall_cnt", d), 32'(cnt_a[d]), x.ecnt);
      if (x.ewb >= 0) chk($sformatf("dut%0d wb_dst", d), 32'(wb_a[d]), x.ewb);
    end
    @(posedge clk);
    model_clock();
  endtask

  vec_t tbl [25];
  vec_t x;

  initial begin
    rst_n = 0; hold = 0; flush = 0; id_valid = 0; id_rs = '0; id_rs_used = 0;
    id_rt = '0; id_rt_used = 0; id_dst = '0; id_wr = 0; id_is_load = 0;

    //          r h f v  rs u rt u dst w l   st rs rt sv cnt wb
    tbl[0]  = '{0,0,0,0, 0,0, 0,0,  0,0,0,  -1, 0, 0, 0, 0,-1};
    tbl[1]  = '{1,0,0,1, 0,0, 0,0,  3,1,0,   0, 0, 0, 0, 0,-1};  // add r3
    tbl[2]  = '{1,0,0,1, 3,1, 0,0,  0,0,0,   0, 1, 0, 1, 0,-1};  // rs=r3 from EX
    tbl[3]  = '{1,0,0,1, 0,0, 3,1,  0,0,0,   0, 0, 2, 2, 0,-1};  // rt=r3 from MEM
    tbl[4]  = '{1,0,0,1, 0,0, 0,0,  5,1,1,   0, 0, 0, 4, 0, 3};  // lw r5
    tbl[5]  = '{1,0,0,1, 0,0, 5,1,  0,0,0,   1, 0, 0, 1, 0,-1};  // load-use stall
    tbl[6]  = '{1,0,0,1, 0,0, 5,1,  0,0,0,   0, 0, 2, 2, 1,-1};
    tbl[7]  = '{1,0,0,1, 0,1, 0,0,  0,1,0,   0, 0, 0, 4, 1, 5};  // dst r0, read r0
    tbl[8]  = '{1,0,0,1, 0,0, 0,0,  4,1,0,   0, 0, 0, 0, 1,-1};
    tbl[9]  = '{1,0,0,1, 0,0, 0,0,  4,1,0,   0, 0, 0, 1, 1,-1};
    tbl[10] = '{1,0,0,1, 4,1, 4,0,  0,0,0,   0, 1, 0, 3, 1,-1};  // youngest r4 wins
    tbl[11] = '{1,0,0,1, 0,0, 0,0,  6,1,1,   0, 0, 0, 6, 1, 4};  // lw r6
    tbl[12] = '{1,1,0,1, 6,1, 0,0,  0,0,0,   1, 0, 0, 5, 1, 4};  // hold x3
    tbl[13] = '{1,1,0,1, 6,1, 0,0,  0,0,0,   1, 0, 0, 5, 1, 4};
    tbl[14] = '{1,1,0,1, 6,1, 0,0,  0,0,0,   1, 0, 0, 5, 1, 4};
    tbl[15] = '{1,0,0,1, 6,1, 0,0,  0,0,0,   1, 0, 0, 5, 1, 4};
    tbl[16] = '{1,0,0,1, 6,1, 0,0,  0,0,0,   0, 2, 0, 2, 2,-1};
    tbl[17] = '{1,0,0,1, 0,0, 0,0,  9,1,1,   0, 0, 0, 4, 2, 6};  // lw r9
    tbl[18] = '{1,0,1,1, 9,1, 0,0, 10,1,0,   0, 1, 0, 1, 2,-1};  // flush beats load-use
    tbl[19] = '{1,0,0,0, 9,1, 0,0,  0,0,0,   0, 2, 0, 2, 2,-1};
    tbl[20] = '{1,0,0,1, 0,0, 0,0,  1,1,0,   0, 0, 0, 4, 2, 9};
    tbl[21] = '{1,0,0,1, 0,0, 0,0,  2,1,0,   0, 0, 0, 1, 2,-1};
    tbl[22] = '{1,0,0,1, 0,0, 0,0,  3,1,0,   0, 0, 0, 3, 2,-1};
    tbl[23] = '{0,1,0,0, 0,0, 0,0,  0,0,0,   0, 0, 0, 7, 2, 1};  // reset under hold
    tbl[24] = '{1,0,0,0, 3,1, 2,1,  0,0,0,   0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 25; i++) apply(tbl[i], 0);

    // No-bypass: reader waits until the producer reaches WB.
    apply('{0,0,0,0, 0,0,0,0, 0,0,0, -1,0,0,0,0,-1}, 1);
    apply('{1,0,0,1, 0,0,0,0, 7,1,0,  0,0,0,0,0,-1}, 1);
    apply('{1,0,0,1, 7,1,0,0, 0,0,0,  1,0,0,1,0,-1}, 1);
    apply('{1,0,0,1, 7,1,0,0, 0,0,0,  1,0,0,2,1,-1}, 1);
    apply('{1,0,0,1, 7,1,0,0, 0,0,0,  0,0,0,4,2, 7}, 1);

    // Counter saturation on the 2-bit instance through repeated load-use stalls.
    apply('{0,0,0,0, 0,0,0,0, 0,0,0, -1,0,0,0,0,-1}, 2);
    for (int i = 0; i < 5; i++) begin
      apply('{1,0,0,1, 0,0,0,0, 5,1,1, -1,0,0,0,0,-1}, 2);
      apply('{1,0,0,1, 0,0,5,1, 0,0,0,  1,0,0,1,(i < 3) ? i : 3,-1}, 2);
      apply('{1,0,0,1, 0,0,5,1, 0,0,0,  0,0,2,2,(i + 1 < 3) ? i + 1 : 3,-1}, 2);
    end
    apply('{1,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,4,3, 5}, 2);
    apply('{1,0,0,0, 0,0,0,0, 0,0,0,  0,0,0,0,5,-1}, 0);

    // Random traffic over a small register window to force frequent matches.
    for (int i = 0; i < 2000; i++) begin
      x.r   = ($urandom_range(0, 63) != 0) ? 1 : 0;
      x.h   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      x.f   = ($urandom_range(0, 7) == 0) ? 1 : 0;
      x.v   = ($urandom_range(0, 9) != 0) ? 1 : 0;
      x.rs  = $urandom_range(0, 7);
      x.rsu = $urandom_range(0, 1);
      x.rt  = $urandom_range(0, 7);
      x.rtu = $urandom_range(0, 1);
      x.dst = $urandom_range(0, 7);
      x.wr  = $urandom_range(0, 1);
      x.ld  = $urandom_range(0, 1);
      x.est = -1; x.ers = 0; x.ert = 0; x.esv = 0; x.ecnt = 0; x.ewb = -1;
      apply(x, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
